// File: rtl/svi_latch_arbiter.sv
// rtl/svi_latch_arbiter.sv - round-robin arbiter sharing one SVI capture latch between requesters
// Optional build macro: SVI_LATCH_ARB_BITREV_EN (capture the selected word bit-reversed).
module svi_latch_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_en,
  output logic [WIDTH-1:0]       o_d,
  output logic                   o_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_SETTLE,
    ST_ACK
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  ptr, ptr_n;
  logic [PW-1:0]  sel, sel_n;
  logic [3:0]     cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n, ack_n;
  logic           en_n, busy_n;
  logic [WIDTH-1:0] d_n;

  logic [PW-1:0]  idx;
  logic [PW-1:0]  pick;
  logic           found;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] cap;

  // Priority search starting at ptr and wrapping past the last requester.
  always_comb begin
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == PW'(k)) word = i_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef SVI_LATCH_ARB_BITREV_EN
  always_comb begin
    cap = '0;
    for (int b = 0; b < WIDTH; b++) cap[b] = word[WIDTH-1-b];
  end
`else
  always_comb begin
    cap = word;
  end
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    cnt_n   = cnt;
    d_n     = o_d;
    gnt_n   = '0;
    ack_n   = '0;
    en_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_OPEN;
          sel_n   = pick;
          d_n     = cap;
          gnt_n   = ONE << pick;
          en_n    = 1'b1;
        end
      end
      ST_OPEN: begin
        gnt_n = ONE << sel;
        if (SETTLE > 0) begin
          state_n = ST_SETTLE;
          cnt_n   = SETTLE_LD;
        end else begin
          state_n = ST_ACK;
          ack_n   = ONE << sel;
        end
      end
      ST_SETTLE: begin
        gnt_n = ONE << sel;
        if (cnt == 4'd0) begin
          state_n = ST_ACK;
          ack_n   = ONE << sel;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_ACK: begin
        state_n = ST_IDLE;
        ptr_n   = (sel == LAST) ? '0 : sel + PW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      sel    <= '0;
      cnt    <= '0;
      o_gnt  <= '0;
      o_ack  <= '0;
      o_en   <= 1'b0;
      o_d    <= '0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      sel    <= sel_n;
      cnt    <= cnt_n;
      o_gnt  <= gnt_n;
      o_ack  <= ack_n;
      o_en   <= en_n;
      o_d    <= d_n;
      o_busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_svi_latch_arbiter.sv
// tb/tb_svi_latch_arbiter.sv - bench for svi_latch_arbiter with SETTLE=1 and SETTLE=0 instances
module tb_svi_latch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data;

  logic [3:0] gnt_a, ack_a, d_a, gnt_b, ack_b, d_b;
  logic       en_a, busy_a, en_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  svi_latch_arbiter #(.N_REQ(4), .WIDTH(4), .SETTLE(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_gnt(gnt_a), .o_ack(ack_a), .o_en(en_a), .o_d(d_a), .o_busy(busy_a)
  );

  svi_latch_arbiter #(.N_REQ(4), .WIDTH(4), .SETTLE(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_gnt(gnt_b), .o_ack(ack_b), .o_en(en_b), .o_d(d_b), .o_busy(busy_b)
  );

  function automatic logic [3:0] cap_word(int s, logic [15:0] dv);
    logic [3:0] w;
    logic [3:0] r;
    w = dv[s*4 +: 4];
`ifdef SVI_LATCH_ARB_BITREV_EN
    for (int b = 0; b < 4; b++) r[b] = w[3-b];
`else
    r = w;
`endif
    return r;
  endfunction

  // Transaction model: t = cycles since grant (-1 when idle), per instance.
  int         ms[2] = '{1, 0};
  int         mt[2] = '{-1, -1};
  int         mptr[2] = '{0, 0};
  int         msel[2] = '{0, 0};
  logic [3:0] md[2] = '{4'd0, 4'd0};
  bit         mvalid = 1'b0;
  int         f;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mt[k] = -1; mptr[k] = 0; md[k] = 4'd0; mvalid = 1'b1;
      end else if (mt[k] < 0) begin
        f = -1;
        for (int i = 0; i < 4; i++)
          if (f < 0 && req[(mptr[k] + i) % 4]) f = (mptr[k] + i) % 4;
        if (f >= 0) begin
          msel[k] = f; md[k] = cap_word(f, data); mt[k] = 0;
        end
      end else begin
        mt[k] = mt[k] + 1;
        if (mt[k] > ms[k] + 1) begin
          mt[k] = -1; mptr[k] = (msel[k] + 1) % 4;
        end
      end
    end
  end

  function automatic logic [13:0] model_out(int k);
    logic [3:0] g, a;
    g = (mt[k] >= 0) ? 4'(1 << msel[k]) : 4'd0;
    a = (mt[k] == ms[k] + 1) ? 4'(1 << msel[k]) : 4'd0;
    return {g, a, mt[k] == 0, md[k], mt[k] >= 0};
  endfunction

  always @(negedge clk) begin
    logic [13:0] act, expv;
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        act  = (k == 0) ? {gnt_a, ack_a, en_a, d_a, busy_a} : {gnt_b, ack_b, en_b, d_b, busy_b};
        expv = model_out(k);
        n_vec++;
        if (act !== expv) begin
          n_err++;
          $display("FAIL model_cmp inst%0d t=%0t got gnt/ack/en/d/busy=%h want %h", k, $time, act, expv);
        end
      end
    end
  end

  task automatic chk(string name, int act, int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

`ifdef SVI_LATCH_ARB_BITREV_EN
  localparam logic [3:0] EA = 4'h5, E3 = 4'hC, E7 = 4'hE;
`else
  localparam logic [3:0] EA = 4'hA, E3 = 4'h3, E7 = 4'h7;
`endif

  initial begin
    rst = 1'b1; req = 4'd0; data = 16'd0;
    cyc(); cyc();
    chk("reset_a", {gnt_a, ack_a, en_a, d_a, busy_a}, 0);
    chk("reset_b", {gnt_b, ack_b, en_b, d_b, busy_b}, 0);
    rst = 1'b0;
    cyc();

    // single request on requester 1
    req = 4'b0010; data = 16'h00A0;
    cyc();
    chk("single_en_c1", en_a, 1);
    chk("single_gnt_c1", gnt_a, 4'b0010);
    chk("single_d_c1", d_a, EA);
    req = 4'd0;
    cyc();
    chk("single_en_c2", en_a, 0);
    cyc();
    chk("single_ack_c3", ack_a, 4'b0010);
    cyc();
    chk("single_busy_c4", busy_a, 0);

    // SETTLE=0 instance plus late data change during OPEN
    req = 4'b0001; data = 16'h0003;
    cyc();
    chk("s0_en_c1", en_b, 1);
    chk("s0_gnt_c1", gnt_b, 4'b0001);
    chk("s0_d_c1", d_b, E3);
    req = 4'd0; data = 16'h000F;
    cyc();
    chk("s0_ack_c2", ack_b, 4'b0001);
    chk("s0_busy_c2", busy_b, 1);
    chk("late_data_b", d_b, E3);
    chk("late_data_a", d_a, E3);
    cyc();
    chk("s0_busy_c3", busy_b, 0);
    chk("s0_ack_c3", ack_b, 0);
    cyc();

    // requester 2 drops its request during SETTLE
    req = 4'b0100; data = 16'h0700;
    cyc();
    cyc();
    req = 4'd0;
    cyc();
    chk("drop_ack", ack_a, 4'b0100);
    chk("drop_d", d_a, E7);
    cyc();

    // reset during SETTLE, then all requesters held
    req = 4'b1000; data = 16'h9000;
    cyc();
    cyc();
    rst = 1'b1; req = 4'd0;
    cyc();
    chk("midrst_a", {gnt_a, ack_a, en_a, d_a, busy_a}, 0);
    chk("midrst_b", {gnt_b, ack_b, en_b, d_b, busy_b}, 0);
    rst = 1'b0; req = 4'b1111;
    cyc();
    chk("rr_gnt0", gnt_a, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      repeat (4) cyc();
      chk($sformatf("rr_gnt%0d", i), gnt_a, 1 << (i % 4));
    end
    req = 4'd0;
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
